// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - panel IDs, timing-set struct and FSM states for the LCD timing generator
package lcd_timing_pkg;

   localparam logic [15:0] ID_4342 = 16'h4342;
   localparam logic [15:0] ID_7084 = 16'h7084;
   localparam logic [15:0] ID_7016 = 16'h7016;
   localparam logic [15:0] ID_4384 = 16'h4384;
   localparam logic [15:0] ID_1018 = 16'h1018;

   typedef struct packed {
      logic [10:0] h_sync;
      logic [10:0] h_back;
      logic [10:0] h_disp;
      logic [10:0] h_front;
      logic [10:0] v_sync;
      logic [10:0] v_back;
      logic [10:0] v_disp;
      logic [10:0] v_front;
   } lcd_timing_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN
   } lcd_state_t;

endpackage

// File: rtl/lcd_timing_lut.sv
// rtl/lcd_timing_lut.sv - combinational panel ID to timing-set lookup
module lcd_timing_lut
   import lcd_timing_pkg::*;
(
   input  logic [15:0] i_lcd_id,
   output lcd_timing_t o_timing,
   output logic        o_known
);

   always_comb begin
      o_timing = '0;
      o_known  = 1'b1;
      case (i_lcd_id)
         ID_4342: o_timing = '{11'd41,  11'd2,   11'd480,  11'd2,   11'd10, 11'd2,  11'd272, 11'd4};
         ID_7084: o_timing = '{11'd128, 11'd88,  11'd800,  11'd40,  11'd2,  11'd33, 11'd480, 11'd10};
         ID_7016: o_timing = '{11'd20,  11'd140, 11'd1024, 11'd160, 11'd3,  11'd20, 11'd600, 11'd12};
         ID_4384: o_timing = '{11'd128, 11'd88,  11'd800,  11'd40,  11'd2,  11'd33, 11'd480, 11'd10};
         ID_1018: o_timing = '{11'd10,  11'd80,  11'd1280, 11'd70,  11'd3,  11'd10, 11'd800, 11'd10};
         default: o_known  = 1'b0;
      endcase
   end

endmodule

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - latches panel timing by ID and generates sync/DE/request strobes
module lcd_timing_gen
   import lcd_timing_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] lcd_id,
   output logic        lcd_hs,
   output logic        lcd_vs,
   output logic        lcd_de,
   output logic        data_req,
   output logic [10:0] pixel_xpos,
   output logic [10:0] pixel_ypos,
   output logic [10:0] h_disp,
   output logic [10:0] v_disp,
   output logic        frame_start,
   output logic        running
);

   lcd_state_t  r_state, w_next;
   lcd_timing_t w_lut;
   logic        w_known;

   lcd_timing_t r_timing;
   logic [10:0] r_h_total, r_v_total;
   logic [10:0] r_hs_start, r_hs_end, r_vs_start, r_vs_end;
   logic [10:0] r_h_cnt, r_v_cnt;

   logic        r_lcd_hs, r_lcd_vs, r_lcd_de, r_data_req, r_frame_start, r_running;
   logic [10:0] r_xpos, r_ypos, r_h_disp, r_v_disp;

   logic        w_run, w_h_act, w_h_req, w_v_act;
   logic [10:0] w_h_next;

   lcd_timing_lut u_lut (
      .i_lcd_id (lcd_id),
      .o_timing (w_lut),
      .o_known  (w_known)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_known) w_next = ST_LOAD;
         ST_LOAD: w_next = ST_RUN;
         ST_RUN:  w_next = ST_RUN;
         default: w_next = ST_IDLE;
      endcase
   end

   // Window edges are precomputed once so the per-pixel compares stay simple.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timing   <= '0;
         r_h_total  <= '0;
         r_v_total  <= '0;
         r_hs_start <= '0;
         r_hs_end   <= '0;
         r_vs_start <= '0;
         r_vs_end   <= '0;
      end else if (r_state == ST_LOAD) begin
         r_timing   <= w_lut;
         r_h_total  <= w_lut.h_sync + w_lut.h_back + w_lut.h_disp + w_lut.h_front;
         r_v_total  <= w_lut.v_sync + w_lut.v_back + w_lut.v_disp + w_lut.v_front;
         r_hs_start <= w_lut.h_sync + w_lut.h_back;
         r_hs_end   <= w_lut.h_sync + w_lut.h_back + w_lut.h_disp;
         r_vs_start <= w_lut.v_sync + w_lut.v_back;
         r_vs_end   <= w_lut.v_sync + w_lut.v_back + w_lut.v_disp;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_state != ST_RUN) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == r_h_total - 11'd1) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == r_v_total - 11'd1) ? 11'd0 : r_v_cnt + 11'd1;
      end else begin
         r_h_cnt <= r_h_cnt + 11'd1;
      end
   end

   // The request window is the DE window shifted one column early: test h_cnt+1.
   assign w_run    = (r_state == ST_RUN);
   assign w_h_next = r_h_cnt + 11'd1;
   assign w_h_act  = (r_h_cnt >= r_hs_start) && (r_h_cnt < r_hs_end);
   assign w_h_req  = (w_h_next >= r_hs_start) && (w_h_next < r_hs_end);
   assign w_v_act  = (r_v_cnt >= r_vs_start) && (r_v_cnt < r_vs_end);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lcd_hs      <= 1'b1;
         r_lcd_vs      <= 1'b1;
         r_lcd_de      <= 1'b0;
         r_data_req    <= 1'b0;
         r_frame_start <= 1'b0;
         r_running     <= 1'b0;
         r_xpos        <= '0;
         r_ypos        <= '0;
         r_h_disp      <= '0;
         r_v_disp      <= '0;
      end else begin
         r_lcd_hs      <= !(w_run && (r_h_cnt < r_timing.h_sync));
         r_lcd_vs      <= !(w_run && (r_v_cnt < r_timing.v_sync));
         r_lcd_de      <= w_run && w_h_act && w_v_act;
         r_data_req    <= w_run && w_h_req && w_v_act;
         r_frame_start <= w_run && (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);
         r_running     <= w_run;
         r_xpos        <= (w_run && w_h_req && w_v_act) ? w_h_next - r_hs_start : 11'd0;
         r_ypos        <= (w_run && w_h_req && w_v_act) ? r_v_cnt - r_vs_start : 11'd0;
         r_h_disp      <= w_run ? r_timing.h_disp : 11'd0;
         r_v_disp      <= w_run ? r_timing.v_disp : 11'd0;
      end
   end

   assign lcd_hs      = r_lcd_hs;
   assign lcd_vs      = r_lcd_vs;
   assign lcd_de      = r_lcd_de;
   assign data_req    = r_data_req;
   assign frame_start = r_frame_start;
   assign running     = r_running;
   assign pixel_xpos  = r_xpos;
   assign pixel_ypos  = r_ypos;
   assign h_disp      = r_h_disp;
   assign v_disp      = r_v_disp;

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Downstream consumer of the panel-ID stage in the RGB LCD driver. It takes the 16-bit panel ID produced at power-up and latches the matching horizontal/vertical timing set. It then generates the sync and data-enable strobes, the pixel coordinates and a one-cycle-early pixel request for the pixel source. It sits between the ID reader and the LCD output pins and runs in the pixel-clock domain.

## Interface
- No parameters. All timing sets are constants in the shared package.
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- lcd_id  in  16  panel ID from the ID stage: 0 = not yet read or unknown
- lcd_hs  out  1  horizontal sync, active-low
- lcd_vs  out  1  vertical sync, active-low
- lcd_de  out  1  data enable, high during active pixels
- data_req  out  1  pixel request, one cycle ahead of lcd_de
- pixel_xpos  out  11  column of the pixel being requested; 0 when data_req = 0
- pixel_ypos  out  11  row of the pixel being requested; 0 when data_req = 0
- h_disp  out  11  active width of the latched panel
- v_disp  out  11  active height of the latched panel
- frame_start  out  1  one-cycle pulse at h_cnt = 0, v_cnt = 0
- running  out  1  high once a timing set is latched

## Operation
- Timing sets, in the order ID: H sync/back/disp/front (total); V sync/back/disp/front (total):
  - 4342: H 41/2/480/2 (525); V 10/2/272/4 (288)
  - 7084: H 128/88/800/40 (1056); V 2/33/480/10 (525)
  - 7016: H 20/140/1024/160 (1344); V 3/20/600/12 (635)
  - 4384: H 128/88/800/40 (1056); V 2/33/480/10 (525)
  - 1018: H 10/80/1280/70 (1440); V 3/10/800/10 (823)
- State machine: IDLE -> LOAD -> RUN.
  - IDLE: lcd_id is sampled every cycle. A known ID moves to LOAD. Zero or an unknown ID stays in IDLE with all strobes inactive.
  - LOAD: one cycle. The lookup result is registered into the timing regs and both counters are cleared. Next state is RUN.
  - RUN: terminal until reset. Changes on lcd_id are ignored.
- Counters (11 bits): h_cnt counts 0..H_TOTAL-1 and then wraps. v_cnt increments on the h_cnt wrap and itself wraps 0..V_TOTAL-1. Both are held at 0 outside RUN.
- Let HS = H_SYNC+H_BACK and VS = V_SYNC+V_BACK.
  - lcd_hs is low iff h_cnt < H_SYNC.
  - lcd_vs is low iff v_cnt < V_SYNC.
  - lcd_de is high iff HS <= h_cnt < HS+H_DISP and VS <= v_cnt < VS+V_DISP.
  - data_req is the same as lcd_de but uses the window HS-1 <= h_cnt < HS+H_DISP-1.
  - pixel_xpos = h_cnt+1-HS and pixel_ypos = v_cnt-VS while data_req = 1.
- All combinations use full 11-bit unsigned comparisons, with no truncation. H_TOTAL is at most 1440, which fits in 11 bits.
- Outside RUN: lcd_hs = 1, lcd_vs = 1, and all other strobes and coordinates are 0.

## Timing
- Reset values: lcd_hs = 1, lcd_vs = 1. lcd_de, data_req, frame_start and running are 0. pixel_xpos, pixel_ypos, h_disp and v_disp are 0. State is IDLE.
- All outputs are registered and decoded from the counter value of the previous cycle. Latency from counter to pin is 1 cycle, and it is identical for every strobe, so relative alignment between strobes is preserved.
- If lcd_id becomes valid at edge N: LOAD at N+1, RUN with h_cnt = 0 at N+2, then running = 1 and the first frame_start at N+3.
- data_req leads lcd_de by exactly 1 cycle. For each active line, data_req is high for exactly H_DISP cycles.
- Reset asserted mid-frame returns the block to IDLE immediately and asynchronously. All outputs go to their reset values. After release the ID is re-latched.

## Structure
- Package lcd_timing_pkg holds:
  - ID constants (ID_4342, ID_7084, ID_7016, ID_4384, ID_1018)
  - a struct typedef lcd_timing_t with eight 11-bit fields
  - the state enum
- Sub-module lcd_timing_lut is purely combinational: lcd_id -> lcd_timing_t plus a known flag.
- The top level holds the FSM, the counters and the output registers.

## Test plan
- lcd_id = 16'h4342 from reset release: running = 1 three cycles after the ID becomes valid. Check line period 525, lcd_hs low 41 cycles, lcd_de 480 cycles per line on 272 lines, frame period 525*288 cycles.
- lcd_id = 16'h1018: check h_disp = 1280, v_disp = 800 and frame period 1440*823. pixel_xpos runs 0..1279 with data_req high, exactly one cycle before lcd_de.
- lcd_id = 0 for 100 cycles, then 16'h7016: the block stays IDLE with hs/vs high and de low throughout the zero period, then runs the 1344x635 timing.
- lcd_id = 16'h1234: the block stays in IDLE indefinitely and running = 0.
- In RUN at 7084, change lcd_id to 16'h4342: the timing stays at 1056/525 and is unchanged.
- Assert rst mid-line at 4384: all outputs reach reset values without a clock edge. After release with the ID still 4384, timing restarts and frame_start is seen 3 cycles after the ID is sampled.
